chien_ctrl: RTL and testbench

Sequencing controller for the parallel Chien search in the RS decoder. It accepts one error-locator polynomial degree per codeword from the Berlekamp-Massey stage and steps an external ROOTS_PER_CYCLE-lane evaluator across all ROOTS_NUM__CHIEN candidates in CYCLES_NUM__CHIEN beats. It collects the per-beat root-hit vectors, counts roots, and reports the root count with a decode-failure flag to the Forney/correction stage.

---
 rtl/gf_pkg.sv | 24 ++
 rtl/chien_popcnt.sv | 29 ++
 rtl/chien_ctrl.sv | 146 ++++++++++++++
 tb/tb_chien_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared RS decoder constants and Chien search controller types.
// Chien scan geometry: ROOTS_PER_CYCLE lanes over CYCLES_NUM__CHIEN beats.
package gf_pkg;

   localparam int unsigned T_LEN             = 16;
   localparam int unsigned LEN_WIDTH         = $clog2(T_LEN + 1);
   localparam int unsigned ROOTS_PER_CYCLE   = 32;
   localparam int unsigned ROOTS_NUM__CHIEN  = 254;
   localparam int unsigned CYCLES_NUM__CHIEN = 8;
   localparam int unsigned CNTR_WIDTH__CHIEN = 3;
   localparam int unsigned ROOT_CNT_WIDTH    = $clog2(ROOTS_NUM__CHIEN + 1);
   // Valid lanes in the final beat; the rest lie past the last candidate.
   localparam int unsigned LAST_LANES        =
      ROOTS_NUM__CHIEN - (CYCLES_NUM__CHIEN - 1) * ROOTS_PER_CYCLE;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SCAN,
      DRAIN,
      DONE
   } chien_state_t;

endpackage

// File: rtl/chien_popcnt.sv
// Combinational population count of one beat of Chien root-hit lanes,
// reduced as a balanced pairwise adder tree.
module chien_popcnt #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 8
) (
   input  logic [IN_W-1:0]  bits,
   output logic [OUT_W-1:0] count
);

   localparam int unsigned LEAVES = 1 << $clog2(IN_W);

   function automatic logic [OUT_W-1:0] tree_sum(input logic [IN_W-1:0] v);
      logic [OUT_W-1:0] acc [LEAVES];
      for (int unsigned i = 0; i < LEAVES; i++) begin
         acc[i] = (i < IN_W) ? OUT_W'(v[i]) : '0;
      end
      // Each pass halves the live width; acc[j] only overwrites already-read slots.
      for (int unsigned w = LEAVES / 2; w > 0; w = w / 2) begin
         for (int unsigned j = 0; j < w; j++) begin
            acc[j] = acc[2*j] + acc[2*j+1];
         end
      end
      return acc[0];
   endfunction

   assign count = tree_sum(bits);

endmodule

// File: rtl/chien_ctrl.sv
// Chien search sequencer: issues evaluator beats for one locator, collects
// root hits in order, and reports root count plus decode-failure flag.
module chien_ctrl
   import gf_pkg::*;
#(
   parameter int unsigned ROOTS_PER_CYCLE   = gf_pkg::ROOTS_PER_CYCLE,
   parameter int unsigned ROOTS_NUM__CHIEN  = gf_pkg::ROOTS_NUM__CHIEN,
   parameter int unsigned CYCLES_NUM__CHIEN = gf_pkg::CYCLES_NUM__CHIEN,
   parameter int unsigned CNTR_WIDTH__CHIEN = gf_pkg::CNTR_WIDTH__CHIEN
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         loc_valid,
   output logic                         loc_ready,
   input  logic [LEN_WIDTH-1:0]         loc_deg,
   output logic                         eval_start,
   output logic                         eval_en,
   output logic [CNTR_WIDTH__CHIEN-1:0] eval_cntr,
   input  logic                         eval_hit_valid,
   input  logic [ROOTS_PER_CYCLE-1:0]   eval_hit,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [ROOT_CNT_WIDTH-1:0]    res_roots,
   output logic                         res_fail
);

   localparam int unsigned LAST_LANES_P =
      ROOTS_NUM__CHIEN - (CYCLES_NUM__CHIEN - 1) * ROOTS_PER_CYCLE;
   localparam logic [CNTR_WIDTH__CHIEN-1:0] LAST_BEAT =
      CNTR_WIDTH__CHIEN'(CYCLES_NUM__CHIEN - 1);
   localparam logic [ROOT_CNT_WIDTH:0] ROOT_MAX_X =
      (ROOT_CNT_WIDTH + 1)'(ROOTS_NUM__CHIEN);

   function automatic logic [ROOTS_PER_CYCLE-1:0] build_last_mask();
      logic [ROOTS_PER_CYCLE-1:0] m;
      m = '0;
      for (int unsigned l = 0; l < ROOTS_PER_CYCLE; l++) begin
         m[l] = (l < LAST_LANES_P);
      end
      return m;
   endfunction

   localparam logic [ROOTS_PER_CYCLE-1:0] LAST_MASK = build_last_mask();

   chien_state_t                 state;
   logic [LEN_WIDTH-1:0]         deg_q;
   logic [ROOT_CNT_WIDTH-1:0]    root_cnt;
   logic [CNTR_WIDTH__CHIEN-1:0] beat_cnt;
   logic [ROOTS_PER_CYCLE-1:0]   hit_masked;
   logic [ROOT_CNT_WIDTH-1:0]    hit_pop;
   logic [ROOT_CNT_WIDTH:0]      sum_x;
   logic [ROOT_CNT_WIDTH-1:0]    root_next;
   logic                         collect;
   logic                         last_beat;

   assign last_beat  = (beat_cnt == LAST_BEAT);
   assign hit_masked = last_beat ? (eval_hit & LAST_MASK) : eval_hit;
   assign collect    = eval_hit_valid && ((state == SCAN) || (state == DRAIN));

   chien_popcnt #(
      .IN_W  (ROOTS_PER_CYCLE),
      .OUT_W (ROOT_CNT_WIDTH)
   ) u_popcnt (
      .bits  (hit_masked),
      .count (hit_pop)
   );

   assign sum_x     = {1'b0, root_cnt} + {1'b0, hit_pop};
   assign root_next = (sum_x >= ROOT_MAX_X) ? ROOT_MAX_X[ROOT_CNT_WIDTH-1:0]
                                            : sum_x[ROOT_CNT_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         loc_ready  <= 1'b1;
         eval_start <= 1'b0;
         eval_en    <= 1'b0;
         eval_cntr  <= '0;
         res_valid  <= 1'b0;
         res_roots  <= '0;
         res_fail   <= 1'b0;
         deg_q      <= '0;
         root_cnt   <= '0;
         beat_cnt   <= '0;
      end else begin
         eval_start <= 1'b0;
         case (state)
            IDLE: begin
               if (loc_valid) begin
                  deg_q     <= loc_deg;
                  root_cnt  <= '0;
                  beat_cnt  <= '0;
                  loc_ready <= 1'b0;
                  if (loc_deg == '0) begin
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_roots <= '0;
                     res_fail  <= 1'b0;
                  end else begin
                     state      <= START;
                     eval_start <= 1'b1;
                  end
               end
            end
            START: begin
               state     <= SCAN;
               eval_en   <= 1'b1;
               eval_cntr <= '0;
            end
            SCAN, DRAIN: begin
               if (state == SCAN) begin
                  if (eval_cntr == LAST_BEAT) begin
                     state     <= DRAIN;
                     eval_en   <= 1'b0;
                     eval_cntr <= '0;
                  end else begin
                     eval_cntr <= eval_cntr + 1'b1;
                  end
               end
               // Final return beat overrides the SCAN->DRAIN step above.
               if (collect) begin
                  root_cnt <= root_next;
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     state     <= DONE;
                     eval_en   <= 1'b0;
                     eval_cntr <= '0;
                     res_valid <= 1'b1;
                     res_roots <= root_next;
                     res_fail  <= (root_next != ROOT_CNT_WIDTH'(deg_q));
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  loc_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chien_ctrl.sv
// Randomized and directed bench for chien_ctrl against a timeline-level
// reference model of the scan, hit accounting and result handshake.
module tb_chien_ctrl;

   localparam int NBEAT = 8;
   localparam int LASTL = 30;
   localparam int RMAX  = 254;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        loc_valid = 1'b0;
   logic        loc_ready;
   logic [4:0]  loc_deg = '0;
   logic        eval_start;
   logic        eval_en;
   logic [2:0]  eval_cntr;
   logic        eval_hit_valid;
   logic [31:0] eval_hit;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [7:0]  res_roots;
   logic        res_fail;

   always #5 clk = ~clk;

   chien_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .loc_valid      (loc_valid),
      .loc_ready      (loc_ready),
      .loc_deg        (loc_deg),
      .eval_start     (eval_start),
      .eval_en        (eval_en),
      .eval_cntr      (eval_cntr),
      .eval_hit_valid (eval_hit_valid),
      .eval_hit       (eval_hit),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_roots      (res_roots),
      .res_fail       (res_fail)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] hits [NBEAT];
   int          lat     = 0;
   bit          garbage = 1'b0;

   // Reference model: position on the codeword timeline relative to acceptance.
   bit m_idle = 1'b1;
   bit m_done = 1'b0;
   int m_t = 0, m_deg = 0, m_beats = 0, m_roots = 0, m_res_roots = 0;
   bit m_res_fail = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      int n;
      if (rst) begin
         m_idle = 1'b1;
         m_done = 1'b0;
         m_t    = 0;
         return;
      end
      if (m_idle) begin
         if (loc_valid) begin
            m_idle      = 1'b0;
            m_deg       = int'(loc_deg);
            m_done      = (m_deg == 0);
            m_t         = 1;
            m_beats     = 0;
            m_roots     = 0;
            m_res_roots = 0;
            m_res_fail  = 1'b0;
         end
      end else if (m_done) begin
         if (res_ready) begin
            m_idle = 1'b1;
            m_done = 1'b0;
         end
      end else begin
         if (m_t >= 2 && eval_hit_valid) begin
            n = 0;
            for (int l = 0; l < 32; l++) begin
               if (eval_hit[l] && !(m_beats == NBEAT - 1 && l >= LASTL)) n++;
            end
            m_roots = (m_roots + n > RMAX) ? RMAX : m_roots + n;
            m_beats++;
            if (m_beats == NBEAT) begin
               m_done      = 1'b1;
               m_res_roots = m_roots;
               m_res_fail  = (m_roots != m_deg);
            end
         end
         m_t++;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
      end
   end

   // Single compare process, away from the active edge.
   initial begin
      bit exp_en;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_loc_ready", loc_ready, 1);
            chk("rst_eval_start", eval_start, 0);
            chk("rst_eval_en", eval_en, 0);
            chk("rst_eval_cntr", eval_cntr, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_roots", res_roots, 0);
            chk("rst_res_fail", res_fail, 0);
         end else begin
            exp_en = !m_idle && !m_done && m_deg != 0 && m_t >= 2 && m_t <= NBEAT + 1;
            chk("loc_ready", loc_ready, m_idle);
            chk("eval_start", eval_start, !m_idle && !m_done && m_deg != 0 && m_t == 1);
            chk("eval_en", eval_en, exp_en);
            chk("eval_cntr", eval_cntr, exp_en ? m_t - 2 : 0);
            chk("res_valid", res_valid, m_done);
            if (m_done) begin
               chk("res_roots", res_roots, m_res_roots);
               chk("res_fail", res_fail, m_res_fail);
            end
         end
      end
   end

   // Behavioural evaluator: returns issued beats in order after 'lat' cycles.
   typedef struct {
      int due;
      int beat;
   } ev_t;
   ev_t ev_q[$];

   initial begin
      ev_t e;
      eval_hit_valid = 1'b0;
      eval_hit       = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) ev_q.delete();
         else if (eval_en) ev_q.push_back('{cyc + lat, int'(eval_cntr)});
         if (!rst && ev_q.size() > 0 && ev_q[0].due <= cyc) begin
            e = ev_q.pop_front();
            eval_hit_valid = 1'b1;
            eval_hit       = hits[e.beat];
         end else begin
            eval_hit_valid = garbage && (m_idle || m_done || m_t == 1) && ($urandom_range(0, 1) == 1);
            eval_hit       = $urandom;
         end
      end
   end

   task automatic clear_hits();
      for (int b = 0; b < NBEAT; b++) hits[b] = '0;
   endtask

   // exp_roots < 0: rely on the per-cycle model only; otherwise also pin literals.
   task automatic run_cw(input int deg, input int hold, input int exp_roots,
                         input int exp_fail, input int exp_lat);
      int acc, w;
      w = 0;
      while (!m_idle && w < 300) begin
         @(posedge clk); #1; w++;
      end
      chk("idle_wait", m_idle, 1);
      loc_valid = 1'b1;
      loc_deg   = 5'(deg);
      acc       = cyc;
      @(posedge clk); #1;
      loc_valid = 1'b0;
      loc_deg   = 5'($urandom);
      w = 0;
      while (!res_valid && w < 300) begin
         @(posedge clk); #1; w++;
      end
      chk("res_valid_wait", res_valid, 1);
      if (exp_lat >= 0) chk("res_latency", cyc - acc, exp_lat);
      if (exp_roots >= 0) begin
         chk("lit_roots", res_roots, exp_roots);
         chk("lit_fail", res_fail, exp_fail);
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      if (exp_lat >= 0) chk("ready_after_consume", loc_ready, 1);
   endtask

   initial begin
      int w;
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      clear_hits();
      repeat (3) @(posedge clk);
      #1;
      chk("lit_reset_ready", loc_ready, 1);
      chk("lit_reset_valid", res_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic scan
      clear_hits();
      hits[0] = 32'h1 << 5;
      hits[3] = 32'h1 << 17;
      lat = 0;
      run_cw(2, 0, 2, 0, 10);

      // Root shortfall
      run_cw(3, 1, 2, 1, 10);

      // Last-beat masking: lanes 30 and 31 lie beyond candidate 253
      clear_hits();
      hits[7] = 32'hC000_0001;
      run_cw(1, 0, 1, 0, 10);

      // Zero degree
      run_cw(0, 0, 0, 0, 1);

      // All candidates hit: 7*32+30 = 254 roots
      for (int b = 0; b < NBEAT; b++) hits[b] = '1;
      run_cw(16, 0, 254, 1, 10);

      // Latency 4 with backpressure, then a back-to-back codeword
      clear_hits();
      hits[1] = 32'h0000_0008;
      hits[7] = 32'h6000_0000;
      lat = 4;
      garbage = 1'b1;
      run_cw(2, 5, 2, 0, 14);
      clear_hits();
      hits[2] = 32'h0000_00F0;
      run_cw(4, 0, 4, 0, 14);
      garbage = 1'b0;

      // Mid-scan reset at eval_cntr == 4
      for (int b = 0; b < NBEAT; b++) hits[b] = '1;
      lat = 0;
      loc_valid = 1'b1;
      loc_deg   = 5'd5;
      @(posedge clk); #1;
      loc_valid = 1'b0;
      w = 0;
      while (!(eval_en && eval_cntr == 3'd4) && w < 20) begin
         @(posedge clk); #1; w++;
      end
      chk("reach_cntr4", eval_cntr, 4);
      rst = 1'b1;
      #1;
      chk("mid_rst_loc_ready", loc_ready, 1);
      chk("mid_rst_eval_start", eval_start, 0);
      chk("mid_rst_eval_en", eval_en, 0);
      chk("mid_rst_eval_cntr", eval_cntr, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_res_roots", res_roots, 0);
      chk("mid_rst_res_fail", res_fail, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      clear_hits();
      hits[2] = 32'h1 << 9;
      run_cw(1, 0, 1, 0, 10);

      // Randomized codewords
      for (int i = 0; i < 30; i++) begin
         lat     = $urandom_range(0, 6);
         garbage = ($urandom_range(0, 1) == 1);
         for (int b = 0; b < NBEAT; b++) hits[b] = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 3) == 0) hits[7] = $urandom;
         run_cw($urandom_range(0, 16), $urandom_range(0, 3), -1, 0, -1);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
